// File: rtl/hsv2rgb_stream_ctrl.sv
// Stream controller wrapped around a fixed-latency HSV-to-RGB pipeline: frame sync,
// credit-based flow control, tag alignment, and a first-word-fall-through output FIFO.
module hsv2rgb_stream_ctrl #(
    parameter int PIPE_LAT   = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [8:0]  s_H,
    input  logic [10:0] s_S,
    input  logic [7:0]  s_V,
    input  logic        s_sof,
    input  logic        s_eof,
    output logic [8:0]  p_H,
    output logic [10:0] p_S,
    output logic [7:0]  p_V,
    input  logic [7:0]  p_r,
    input  logic [7:0]  p_g,
    input  logic [7:0]  p_b,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_r,
    output logic [7:0]  m_g,
    output logic [7:0]  m_b,
    output logic        m_sof,
    output logic        m_eof,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        h_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic            fire, accept, drop, credit, fifo_wr, pop;
    logic [CW-1:0]   inflight, fifo_count;
    logic [CW:0]     occupancy;
    logic [PIPE_LAT:0] tag_v, tag_sof, tag_eof;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [25:0]     mem [FIFO_DEPTH];
    logic [25:0]     head;

    // Credit counts every accepted beat until it leaves the FIFO, so a write never overflows.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);
    assign s_ready   = (state == SYNC) || ((state == RUN) && credit);
    assign fire      = s_valid && s_ready;
    assign drop      = fire && !accept;
    assign fifo_wr   = tag_v[PIPE_LAT];
    assign m_valid   = (fifo_count != '0);
    assign pop       = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (en) state_nx = SYNC;
            SYNC: begin
                if (fire && s_sof && credit) begin
                    accept   = 1'b1;
                    state_nx = (s_eof && !en) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    accept = 1'b1;
                    if (s_eof && !en) state_nx = DRAIN;
                end
            end
            DRAIN: if (inflight == '0 && fifo_count == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_H        <= '0;
            p_S        <= '0;
            p_V        <= '0;
            tag_v      <= '0;
            tag_sof    <= '0;
            tag_eof    <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            h_err      <= 1'b0;
        end else begin
            if (fire) begin
                p_H <= s_H;
                p_S <= s_S;
                p_V <= s_V;
            end
            tag_v   <= {tag_v[PIPE_LAT-1:0], accept};
            tag_sof <= {tag_sof[PIPE_LAT-1:0], s_sof};
            tag_eof <= {tag_eof[PIPE_LAT-1:0], s_eof};
            case ({accept, fifo_wr})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (accept && s_eof) frame_cnt <= frame_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            h_err <= accept && (s_H > 9'd360);
        end
    end

    // Storage needs no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= {p_r, p_g, p_b, tag_sof[PIPE_LAT], tag_eof[PIPE_LAT]};
    end

    assign head = mem[rd_ptr];
    assign {m_r, m_g, m_b, m_sof, m_eof} = head;

endmodule

// File: tb/tb_hsv2rgb_stream_ctrl.sv
// Self-checking bench for hsv2rgb_stream_ctrl: a stub fixed-latency HSV-to-RGB pipeline,
// a queue-based reference model, directed scenarios and a randomized phase.
module tb_hsv2rgb_stream_ctrl;

    localparam int PIPE_LAT   = 7;
    localparam int FIFO_DEPTH = 16;

    logic        clk, rst, en, s_valid, s_ready, s_sof, s_eof;
    logic [8:0]  s_H, p_H;
    logic [10:0] s_S, p_S;
    logic [7:0]  s_V, p_V, p_r, p_g, p_b, m_r, m_g, m_b;
    logic        m_valid, m_ready, m_sof, m_eof, h_err;
    logic [15:0] frame_cnt, drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int mr_mode  = 0;
    int cyc      = 0;

    hsv2rgb_stream_ctrl #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_H(s_H), .s_S(s_S), .s_V(s_V), .s_sof(s_sof), .s_eof(s_eof),
        .p_H(p_H), .p_S(p_S), .p_V(p_V), .p_r(p_r), .p_g(p_g), .p_b(p_b),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_sof(m_sof), .m_eof(m_eof),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .h_err(h_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference colour conversion; out-of-range hue yields black.
    function automatic logic [23:0] hsv_to_rgb(input logic [8:0] h, input logic [10:0] s,
                                               input logic [7:0] v);
        int c, f, sec, p, q, t, vi, r, g, b;
        if (h > 9'd360) return 24'h0;
        vi  = int'(v);
        c   = vi * int'(s) / 2047;
        sec = int'(h) / 60;
        f   = int'(h) % 60;
        if (sec == 6) sec = 0;
        p = vi - c;
        q = vi - c * f / 60;
        t = vi - c * (60 - f) / 60;
        case (sec)
            0: begin r = vi; g = t;  b = p;  end
            1: begin r = q;  g = vi; b = p;  end
            2: begin r = p;  g = vi; b = t;  end
            3: begin r = p;  g = q;  b = vi; end
            4: begin r = t;  g = p;  b = vi; end
            default: begin r = vi; g = p; b = q; end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    logic [23:0] pipe [PIPE_LAT];
    always @(posedge clk) begin
        pipe[0] <= hsv_to_rgb(p_H, p_S, p_V);
        for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {p_r, p_g, p_b} = pipe[PIPE_LAT-1];

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eof;
    } beat_t;

    // Model: mode 0 idle, 1 waiting for sof, 2 streaming, 3 draining.
    beat_t exp_q[$];
    int    m_mode   = 0;
    int    m_frames = 0;
    int    m_drops  = 0;
    int    pops     = 0;
    logic  m_herr   = 1'b0;
    logic  started  = 1'b0;

    initial begin : model
        bit f, acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                m_mode = 0; m_frames = 0; m_drops = 0; m_herr = 1'b0;
                started = 1'b1;
            end else if (started) begin
                f = s_valid && s_ready;
                acc = 1'b0;
                m_herr = 1'b0;
                case (m_mode)
                    0: if (en) m_mode = 1;
                    1: if (f) begin
                        if (s_sof && exp_q.size() < FIFO_DEPTH) begin
                            acc = 1'b1;
                            m_mode = (s_eof && !en) ? 3 : 2;
                        end else if (m_drops < 65535) m_drops++;
                    end
                    2: if (f) begin
                        acc = 1'b1;
                        if (s_eof && !en) m_mode = 3;
                    end
                    default: if (exp_q.size() == 0) m_mode = 0;
                endcase
                if (m_valid && m_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
                if (acc) begin
                    exp_q.push_back({hsv_to_rgb(s_H, s_S, s_V), s_sof, s_eof});
                    if (s_eof) m_frames = (m_frames + 1) % 65536;
                    m_herr = (s_H > 9'd360);
                end
            end
        end
    end

    task automatic check_output(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    initial forever begin
        @(negedge clk);
        if (started && !rst) begin
            check_output("s_ready", s_ready,
                         (m_mode == 1) ? 1 : (m_mode == 2) ? longint'(exp_q.size() < FIFO_DEPTH) : 0);
            check_output("frame_cnt", frame_cnt, m_frames);
            check_output("drop_cnt", drop_cnt, m_drops);
            check_output("h_err", h_err, m_herr);
            if (m_valid && exp_q.size() == 0)
                check_output("m_valid_with_nothing_pending", m_valid, 0);
            else if (m_valid && m_ready)
                check_output("out_beat", {m_r, m_g, m_b, m_sof, m_eof}, exp_q[0]);
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                2: m_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic apply_stimulus(input logic [8:0] h, input logic [10:0] s, input logic [7:0] v,
                                  input logic sof, input logic eof);
        int k;
        s_valid = 1'b1; s_H = h; s_S = s; s_V = v; s_sof = sof; s_eof = eof;
        k = 0;
        forever begin
            @(posedge clk);
            if (s_ready) break;
            k++;
            if (k >= 2000) begin
                check_output("fire_timeout", s_ready, 1);
                break;
            end
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic send_random(input logic sof, input logic eof);
        logic [8:0] h;
        h = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(361, 511)) : 9'($urandom_range(0, 360));
        apply_stimulus(h, 11'($urandom), 8'($urandom), sof, eof);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_mode != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (m_mode != 0) begin
            n_checks++;
            $display("[TB] FAIL drain_timeout: still busy after %0d cycles, s_ready=%0b m_valid=%0b",
                     k, s_ready, m_valid);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int c1, lat, mv, hp, p0, len;
        rst = 1'b1; en = 1'b0; s_valid = 1'b0;
        s_H = '0; s_S = '0; s_V = '0; s_sof = 1'b0; s_eof = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_m_valid", m_valid, 0);
        check_output("reset_s_ready", s_ready, 0);
        check_output("reset_h_err", h_err, 0);
        check_output("reset_frame_cnt", frame_cnt, 0);
        check_output("reset_drop_cnt", drop_cnt, 0);
        check_output("reset_p_H", p_H, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] latency and first conversions");
        en = 1'b1;
        apply_stimulus(9'd0, 11'd2047, 8'd255, 1'b1, 1'b0);
        @(negedge clk);
        c1 = cyc;
        en = 1'b0;
        apply_stimulus(9'd120, 11'd2047, 8'd255, 1'b0, 1'b1);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_valid) begin
                lat = cyc - c1 + 1;
                break;
            end
            @(negedge clk);
        end
        check_output("latency", lat, PIPE_LAT + 2);
        check_output("first_rgb", {m_r, m_g, m_b}, 24'hFF0000);
        check_output("first_sof", m_sof, 1);
        @(negedge clk);
        check_output("second_rgb", {m_r, m_g, m_b}, 24'h00FF00);
        check_output("second_eof", m_eof, 1);
        wait_idle();
        check_output("frames_after_first", frame_cnt, 1);

        $display("[TB] sync/drop and drain");
        en = 1'b1;
        repeat (3) send_random(1'b0, 1'b0);
        @(negedge clk);
        check_output("drop_cnt_3", drop_cnt, 3);
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) en = 1'b0;
            send_random(i == 0, i == 9);
        end
        @(negedge clk);
        check_output("s_ready_after_eof", s_ready, 0);
        wait_idle();
        check_output("drain_beats_out", pops - p0, 10);
        check_output("frames_after_drain", frame_cnt, 2);

        $display("[TB] backpressure");
        mr_mode = 1;
        @(negedge clk);
        en = 1'b1;
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            send_random(i == 0, 1'b0);
            if (i == 14) begin
                @(negedge clk);
                check_output("ready_before_16th", s_ready, 1);
            end
        end
        @(negedge clk);
        check_output("not_ready_after_16", s_ready, 0);
        repeat (5) @(negedge clk);
        check_output("still_not_ready", s_ready, 0);
        mr_mode = 0;
        for (int i = 16; i < 40; i++) begin
            if (i == 39) en = 1'b0;
            send_random(1'b0, i == 39);
        end
        wait_idle();
        check_output("backpressure_beats_out", pops - p0, 40);

        $display("[TB] full-boundary pop and fire");
        mr_mode = 1;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 16; i++) send_random(i == 0, 1'b0);
        mr_mode = 3;
        s_valid = 1'b1; s_H = 9'd200; s_S = 11'd1000; s_V = 8'd100; s_sof = 1'b0; s_eof = 1'b0;
        @(negedge clk);
        check_output("full_no_credit", s_ready, 0);
        @(posedge clk); #2 m_ready = 1'b1;
        p0 = pops;
        @(negedge clk);
        check_output("full_still_no_credit", s_ready, 0);
        @(posedge clk); #2 m_ready = 1'b0;
        @(negedge clk);
        check_output("credit_after_one_pop", s_ready, 1);
        check_output("exactly_one_pop", pops - p0, 1);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        check_output("single_fire_refills", s_ready, 0);
        mr_mode = 0;
        en = 1'b0;
        send_random(1'b0, 1'b1);
        wait_idle();

        $display("[TB] reset mid-frame and out-of-range hue");
        mr_mode = 1;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 5; i++) send_random(i == 0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mr_mode = 0;
        mv = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid) mv++;
        end
        check_output("no_output_after_reset", mv, 0);
        check_output("frame_cnt_after_reset", frame_cnt, 0);
        en = 1'b0;
        apply_stimulus(9'd361, 11'd2047, 8'd255, 1'b1, 1'b1);
        @(negedge clk);
        check_output("h_err_pulse", h_err, 1);
        hp = 0;
        mv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (h_err) hp++;
            if (m_valid) begin
                mv = 1;
                break;
            end
        end
        check_output("h_err_single", hp, 0);
        check_output("bad_hue_output_seen", mv, 1);
        check_output("bad_hue_rgb", {m_r, m_g, m_b}, 24'h000000);
        wait_idle();
        check_output("frame_cnt_after_bad_hue", frame_cnt, 1);

        $display("[TB] randomized frames");
        mr_mode = 2;
        for (int fr = 0; fr < 12; fr++) begin
            en = 1'b1;
            repeat ($urandom_range(0, 2)) send_random(1'b0, 1'b0);
            len = $urandom_range(2, 12);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                if (i == len - 1) en = 1'($urandom_range(0, 1));
                else if (i > 0) en = ($urandom_range(0, 3) != 0);
                send_random(i == 0, i == len - 1);
            end
        end
        mr_mode = 0;
        en = 1'b1;
        send_random(1'b1, 1'b0);
        en = 1'b0;
        send_random(1'b0, 1'b1);
        wait_idle();
        check_output("final_queue_empty", m_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hsv2rgb_stream_ctrl.md
HSV2RGB_STREAM_CTRL -- requirements
Module: hsv2rgb_stream_ctrl

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 7, giving the fixed latency in clocks of the attached HSV-to-RGB pipeline from p_H/p_S/p_V to p_r/p_g/p_b.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >= PIPE_LAT+2), giving the output FIFO depth in beats.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 en  in  1  run enable; sampled only as described under Function.
REQ-006 s_valid, s_ready  in/out  1 each  input beat handshake; a beat transfers when both are high (fire).
REQ-007 s_H, s_S, s_V  in  9/11/8  HSV pixel; H is in 0..360.
REQ-008 s_sof, s_eof  in  1 each  first and last beat of a frame.
REQ-009 p_H, p_S, p_V  out  9/11/8  registered drive to the pipeline.
REQ-010 p_r, p_g, p_b  in  8 each  pipeline result.
REQ-011 m_valid, m_ready  out/in  1 each  output handshake.
REQ-012 m_r, m_g, m_b  out  8 each  RGB beat.
REQ-013 m_sof, m_eof  out  1 each  tags aligned to m_r/m_g/m_b.
REQ-014 frame_cnt  out  16  count of completed frames, wrapping.
REQ-015 drop_cnt  out  16  count of discarded beats, saturating at 0xFFFF.
REQ-016 h_err  out  1  one-cycle pulse for each accepted beat with s_H > 360.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, SYNC, RUN, DRAIN.
REQ-018 IDLE: s_ready=0; the FSM SHALL move to SYNC when en=1.
REQ-019 SYNC: s_ready=1 and beats SHALL be discarded (drop_cnt+1 each) until a beat with s_sof=1 arrives while credit is available.
REQ-020 That sof beat SHALL be accepted into the pipeline, and the FSM SHALL enter RUN in the same cycle.
REQ-021 RUN: s_ready SHALL equal (inflight + fifo_count < FIFO_DEPTH), where inflight is the number of accepted beats not yet written to the FIFO.
REQ-022 RUN: an accepted beat with s_eof=1 SHALL increment frame_cnt. If en=0 in that cycle, the FSM SHALL go to DRAIN; otherwise it SHALL stay in RUN.
REQ-023 RUN: an accepted beat with s_sof=1 other than the first SHALL be passed through unchanged, with no resync.
REQ-024 DRAIN: s_ready=0; the FSM SHALL go to IDLE when inflight=0 and the FIFO is empty.
REQ-025 en=0 SHALL never truncate a frame once it has started.
REQ-026 On fire, p_H/p_S/p_V SHALL be loaded with s_H/s_S/s_V the next cycle. They SHALL hold their value when there is no fire.
REQ-027 A tag shift register of length PIPE_LAT+1 SHALL carry {valid, sof, eof} from fire to the cycle in which p_r/p_g/p_b for that beat are valid. In that cycle {p_r, p_g, p_b, sof, eof} SHALL be written to the FIFO.
REQ-028 Latency SHALL be: a fire in cycle t, with the FIFO empty and m_ready=1, gives m_valid=1 with that beat in cycle t+PIPE_LAT+2.
REQ-029 The FIFO SHALL be first-word-fall-through: m_valid = not empty, and a pop occurs on m_valid & m_ready.
REQ-030 The credit rule SHALL guarantee that a FIFO write never finds the FIFO full. No beat SHALL be lost or duplicated under any m_ready pattern.
REQ-031 A fire and a pop in the same cycle SHALL both take effect, and the occupancy/credit accounting SHALL stay exact.
REQ-032 Back-to-back fires SHALL sustain 1 beat/clock while m_ready=1.
REQ-033 A beat with s_H > 360 SHALL still be processed: it pulses h_err one cycle after fire, and its output passes through unmodified (the pipeline yields 0,0,0).
REQ-034 frame_cnt SHALL wrap from 0xFFFF to 0.

Reset
REQ-035 With rst=1 at a clock edge, the FSM SHALL go to IDLE and the tag register and FIFO SHALL be cleared.
REQ-036 Also on reset: inflight=0; frame_cnt=0; drop_cnt=0; p_H/p_S/p_V=0; m_valid=0; s_ready=0; h_err=0.
REQ-037 Reset mid-frame SHALL discard all in-flight and buffered beats, with no output beat after reset until a new sof is accepted.
REQ-038 Outputs SHALL be defined from the first clock edge with rst=1.

Verification
REQ-039 Latency: en=1, send sof beat H=0,S=2047,V=255 at cycle t, m_ready=1 -> m_valid=1 at t+9 (PIPE_LAT=7), with m_sof=1 and RGB equal to the pipeline model output.
REQ-040 Sync/drop: en=1, send 3 beats with sof=0, then 1 sof beat -> drop_cnt=3, and only the sof beat and its followers appear on the output.
REQ-041 Backpressure: stream 40 beats, m_ready=0 throughout -> s_ready falls after exactly 16 accepts; then m_ready=1 -> all 40 beats emerge in order, none lost.
REQ-042 Full-boundary simultaneity: at credit=0, assert m_ready for 1 cycle -> exactly one pop, and s_ready=1 the next cycle for exactly one fire.
REQ-043 Drain: drop en mid-frame of 10 beats -> all 10 beats output, frame_cnt+1, FSM returns to IDLE, s_ready=0 after eof.
REQ-044 Reset mid-frame plus H=361: assert rst with 5 beats in flight -> no further m_valid. Then a new frame with H=361 -> h_err pulses once and the output RGB is 0,0,0.
